// File: rtl/comp_wr_packer_pkg.sv
// Shared types and helpers for the compressed-write packer.
package comp_wr_packer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        AW    = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // AXI size code for a full-width beat
    function automatic logic [2:0] calc_awsize(input int unsigned data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/comp_wr_packer_buf.sv
// Packet beat buffer: registered write port, combinational read port by index.
module comp_wr_packer_buf #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned MAX_BEATS  = 16
) (
    input  logic                         clk,
    input  logic                         i_wr_en,
    input  logic [$clog2(MAX_BEATS)-1:0] i_wr_idx,
    input  logic [DATA_WIDTH-1:0]        i_wr_data,
    input  logic [$clog2(MAX_BEATS)-1:0] i_rd_idx,
    output logic [DATA_WIDTH-1:0]        o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [MAX_BEATS];

    // Contents need no reset: a packet is always rewritten before it is read
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = (32'(i_rd_idx) < MAX_BEATS) ? r_mem[i_rd_idx] : '0;

endmodule

// File: rtl/comp_wr_packer.sv
// Buffers one compressed packet, pairs it with an upstream AW and issues an exact-length AXI burst.
// Optional sticky framing-error output enabled by COMP_WR_PACKER_ERR_EN.
module comp_wr_packer
    import comp_wr_packer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned MAX_BEATS  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  sop_i,
    input  logic                  eop_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic [ID_WIDTH-1:0]   awid_i,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [ADDR_WIDTH-1:0] awaddr_o,
    output logic [ID_WIDTH-1:0]   awid_o,
    output logic [7:0]            awlen_o,
    output logic [2:0]            awsize_o,
    output logic [1:0]            awburst_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  wlast_o
`ifdef COMP_WR_PACKER_ERR_EN
    ,
    output logic                  err_o
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);
    localparam int unsigned IDX_W = $clog2(MAX_BEATS);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);
    localparam logic [2:0] AWSIZE = calc_awsize(DATA_WIDTH);

    state_t                r_state;
    logic [CNT_W-1:0]      r_wr_cnt;
    logic [CNT_W-1:0]      r_rd_cnt;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [ID_WIDTH-1:0]   r_awid;
    logic [7:0]            r_awlen;
    logic                  r_awvalid;
    logic                  r_awready;
    logic                  r_ready;
    logic                  r_wvalid;
    logic                  r_wlast;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_aw_in_hs;
    logic                  w_aw_out_hs;
    logic                  w_w_hs;
    logic                  w_beat;
    logic                  w_room;
    logic [CNT_W-1:0]      w_rd_next;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_aw_in_hs  = awvalid_i && r_awready;
    assign w_aw_out_hs = r_awvalid && awready_i;
    assign w_w_hs      = r_wvalid && wready_i;
    assign w_beat      = valid_i && r_ready;
    assign w_room      = (r_wr_cnt != MAX_CNT);
    assign w_rd_next   = r_rd_cnt + CNT_W'(1);
    // Prefetch the next beat so wdata_o can be a register
    assign w_rd_idx    = (r_state == DRAIN) ? IDX_W'(w_rd_next) : '0;

    comp_wr_packer_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BEATS  (MAX_BEATS)
    ) u_buf (
        .clk       (clk),
        .i_wr_en   (w_beat && w_room),
        .i_wr_idx  (IDX_W'(r_wr_cnt)),
        .i_wr_data (data_i),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_awaddr  <= '0;
            r_awid    <= '0;
            r_awlen   <= '0;
            r_awvalid <= 1'b0;
            r_awready <= 1'b0;
            r_ready   <= 1'b0;
            r_wvalid  <= 1'b0;
            r_wlast   <= 1'b0;
            r_wdata   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_awready <= 1'b1;
                    if (w_aw_in_hs) begin
                        r_awaddr  <= awaddr_i;
                        r_awid    <= awid_i;
                        r_wr_cnt  <= '0;
                        r_awready <= 1'b0;
                        r_ready   <= 1'b1;
                        r_state   <= FILL;
                    end
                end
                FILL: begin
                    // Beats past MAX_BEATS are accepted and dropped; count saturates
                    if (w_beat) begin
                        if (w_room) begin
                            r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                        end
                        if (eop_i) begin
                            r_ready   <= 1'b0;
                            r_awvalid <= 1'b1;
                            r_awlen   <= w_room ? 8'(r_wr_cnt) : 8'(MAX_BEATS - 1);
                            r_state   <= AW;
                        end
                    end
                end
                AW: begin
                    if (w_aw_out_hs) begin
                        r_awvalid <= 1'b0;
                        r_rd_cnt  <= '0;
                        r_wvalid  <= 1'b1;
                        r_wdata   <= w_rd_data;
                        r_wlast   <= (r_wr_cnt == CNT_W'(1));
                        r_state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_w_hs) begin
                        if (r_wlast) begin
                            r_wvalid  <= 1'b0;
                            r_wlast   <= 1'b0;
                            r_awready <= 1'b1;
                            r_state   <= IDLE;
                        end else begin
                            r_rd_cnt <= w_rd_next;
                            r_wdata  <= w_rd_data;
                            r_wlast  <= (w_rd_next == r_wr_cnt - CNT_W'(1));
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready_o   = r_ready;
    assign awready_o = r_awready;
    assign awvalid_o = r_awvalid;
    assign awaddr_o  = r_awaddr;
    assign awid_o    = r_awid;
    assign awlen_o   = r_awlen;
    assign awsize_o  = AWSIZE;
    assign awburst_o = AXI_BURST_INCR;
    assign wvalid_o  = r_wvalid;
    assign wdata_o   = r_wdata;
    assign wlast_o   = r_wlast;

`ifdef COMP_WR_PACKER_ERR_EN
    logic r_err;

    // Sticky: overflow beat, sop mid-packet, or a packet not opened by sop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_beat && (!w_room || (sop_i && (r_wr_cnt != '0)) ||
                                (!sop_i && (r_wr_cnt == '0)))) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    logic w_unused_sop;
    assign w_unused_sop = sop_i;
`endif

endmodule
